// File: rtl/id_stage.sv
// Instruction-decode stage: register file, control decoder, immediate sign-extender and ID/EX register.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle write-back data into the read ports.
module id_stage #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] branch_adder_in,
  output logic [DW-1:0] branch_adder_out,
  input  logic [DW-1:0] instin,
  output logic [DW-1:0] instout,
  input  logic [DW-1:0] writedata,
  input  logic          regwrite_in,
  output logic [DW-1:0] rd_data1,
  output logic [DW-1:0] rd_data2,
  output logic [DW-1:0] sign_ext,
  output logic          regdst,
  output logic          regwrite,
  output logic          alusrc,
  output logic          branch,
  output logic          memwrite,
  output logic          memread,
  output logic          memtoreg,
  output logic [1:0]    aluop
);

  localparam int AW = $clog2(NREG);

  logic [DW-1:0] regs_r [NREG];

  logic [2:0]    op_s;
  logic [AW-1:0] rs_s;
  logic [AW-1:0] rt_s;
  logic [AW-1:0] waddr_s;
  logic          wr_en_s;
  logic [DW-1:0] rdata1_s;
  logic [DW-1:0] rdata2_s;
  logic [DW-1:0] sext_s;

  logic          regdst_s;
  logic          regwrite_s;
  logic          alusrc_s;
  logic          branch_s;
  logic          memwrite_s;
  logic          memread_s;
  logic          memtoreg_s;
  logic [1:0]    aluop_s;

  assign op_s    = instin[15:13];
  assign rs_s    = instin[12:10];
  assign rt_s    = instin[9:7];
  assign waddr_s = (op_s == 3'd0) ? instin[6:4] : instin[9:7];
  assign wr_en_s = regwrite_in && (waddr_s != '0);
  assign sext_s  = {{(DW-7){instin[6]}}, instin[6:0]};

  // Register-file read ports, with optional write-before-read forwarding.
  always_comb begin
    rdata1_s = regs_r[rs_s];
    rdata2_s = regs_r[rt_s];
`ifdef ID_WB_BYPASS_EN
    if (wr_en_s && (waddr_s == rs_s)) begin
      rdata1_s = writedata;
    end else begin
      rdata1_s = regs_r[rs_s];
    end
    if (wr_en_s && (waddr_s == rt_s)) begin
      rdata2_s = writedata;
    end else begin
      rdata2_s = regs_r[rt_s];
    end
`else
    if (rs_s == '0) begin
      rdata1_s = '0;
    end else begin
      rdata1_s = regs_r[rs_s];
    end
    if (rt_s == '0) begin
      rdata2_s = '0;
    end else begin
      rdata2_s = regs_r[rt_s];
    end
`endif
  end

  // Main control decoder: each opcode raises only its own bits.
  always_comb begin
    regdst_s   = 1'b0;
    regwrite_s = 1'b0;
    alusrc_s   = 1'b0;
    branch_s   = 1'b0;
    memwrite_s = 1'b0;
    memread_s  = 1'b0;
    memtoreg_s = 1'b0;
    aluop_s    = 2'b00;
    case (op_s)
      3'd0: begin
        regdst_s   = 1'b1;
        regwrite_s = 1'b1;
        aluop_s    = 2'b10;
      end
      3'd1, 3'd2, 3'd3: begin
        alusrc_s   = 1'b1;
        regwrite_s = 1'b1;
        aluop_s    = 2'b11;
      end
      3'd4, 3'd5: begin
        branch_s   = 1'b1;
        aluop_s    = 2'b01;
      end
      3'd6: begin
        alusrc_s   = 1'b1;
        regwrite_s = 1'b1;
        memread_s  = 1'b1;
        memtoreg_s = 1'b1;
        aluop_s    = 2'b00;
      end
      3'd7: begin
        alusrc_s   = 1'b1;
        memwrite_s = 1'b1;
        aluop_s    = 2'b00;
      end
      default: begin
        aluop_s    = 2'b00;
      end
    endcase
  end

  // Register file: reset loads reg[i] = i; reg0 never takes a write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= DW'(i);
      end
    end else if (wr_en_s) begin
      regs_r[waddr_s] <= writedata;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_adder_out <= '0;
      instout          <= '0;
      rd_data1         <= '0;
      rd_data2         <= '0;
      sign_ext         <= '0;
      regdst           <= 1'b0;
      regwrite         <= 1'b0;
      alusrc           <= 1'b0;
      branch           <= 1'b0;
      memwrite         <= 1'b0;
      memread          <= 1'b0;
      memtoreg         <= 1'b0;
      aluop            <= 2'b00;
    end else begin
      branch_adder_out <= branch_adder_in;
      instout          <= instin;
      rd_data1         <= rdata1_s;
      rd_data2         <= rdata2_s;
      sign_ext         <= sext_s;
      regdst           <= regdst_s;
      regwrite         <= regwrite_s;
      alusrc           <= alusrc_s;
      branch           <= branch_s;
      memwrite         <= memwrite_s;
      memread          <= memread_s;
      memtoreg         <= memtoreg_s;
      aluop            <= aluop_s;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed steps plus random instructions against a behavioural model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] branch_adder_in, branch_adder_out;
  logic [15:0] instin, instout;
  logic [15:0] writedata;
  logic        regwrite_in;
  logic [15:0] rd_data1, rd_data2, sign_ext;
  logic        regdst, regwrite, alusrc, branch, memwrite, memread, memtoreg;
  logic [1:0]  aluop;

  int checks = 0;
  int errors = 0;
  logic [15:0] mreg [8];

  id_stage dut (
    .clk(clk), .reset(reset),
    .branch_adder_in(branch_adder_in), .branch_adder_out(branch_adder_out),
    .instin(instin), .instout(instout),
    .writedata(writedata), .regwrite_in(regwrite_in),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .sign_ext(sign_ext),
    .regdst(regdst), .regwrite(regwrite), .alusrc(alusrc), .branch(branch),
    .memwrite(memwrite), .memread(memread), .memtoreg(memtoreg), .aluop(aluop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mreg[i] = 16'(i);
  endtask

  function automatic logic [15:0] ctrl_of(input logic [15:0] inst);
    int op;
    logic rdst, rwr, asrc, br, mw, mr, m2r;
    logic [1:0] aop;
    op   = int'(inst[15:13]);
    rdst = (op == 0);
    rwr  = (op == 0) || (op >= 1 && op <= 3) || (op == 6);
    asrc = (op >= 1 && op <= 3) || (op >= 6);
    br   = (op == 4) || (op == 5);
    mw   = (op == 7);
    mr   = (op == 6);
    m2r  = (op == 6);
    if (op == 0) aop = 2'd2;
    else if (op <= 3) aop = 2'd3;
    else if (op <= 5) aop = 2'd1;
    else aop = 2'd0;
    return {7'd0, rdst, rwr, asrc, br, mw, mr, m2r, aop};
  endfunction

  function automatic logic [15:0] sext_of(input logic [15:0] inst);
    int v;
    v = int'(inst[6:0]);
    if (v >= 64) v = v - 128;
    return 16'(v);
  endfunction

  function automatic logic [15:0] ctrl_obs();
    return {7'd0, regdst, regwrite, alusrc, branch, memwrite, memread, memtoreg, aluop};
  endfunction

  // One clock of normal operation, checked against the model.
  task automatic step(input logic [15:0] inst, input logic [15:0] ba,
                      input logic [15:0] wd, input logic we, input bit full);
    int rs, rt, wa;
    bit wr;
    logic [15:0] e1, e2;
    rs = int'(inst[12:10]);
    rt = int'(inst[9:7]);
    wa = (inst[15:13] == 3'd0) ? int'(inst[6:4]) : rt;
    wr = we && (wa != 0);
    e1 = mreg[rs];
    e2 = mreg[rt];
`ifdef ID_WB_BYPASS_EN
    if (wr && wa == rs) e1 = wd;
    if (wr && wa == rt) e2 = wd;
`endif
    instin = inst; branch_adder_in = ba; writedata = wd; regwrite_in = we;
    @(posedge clk);
    if (wr) mreg[wa] = wd;
    #1;
    chk("rd_data1", rd_data1, e1);
    chk("rd_data2", rd_data2, e2);
    if (full) begin
      chk("instout", instout, inst);
      chk("branch_adder_out", branch_adder_out, ba);
      chk("sign_ext", sign_ext, sext_of(inst));
      chk("ctrl", ctrl_obs(), ctrl_of(inst));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ba"}, branch_adder_out, 16'h0000);
    chk({tag, "_inst"}, instout, 16'h0000);
    chk({tag, "_rd1"}, rd_data1, 16'h0000);
    chk({tag, "_rd2"}, rd_data2, 16'h0000);
    chk({tag, "_sext"}, sign_ext, 16'h0000);
    chk({tag, "_ctrl"}, ctrl_obs(), 16'h0000);
  endtask

  initial begin
    reset = 1'b0;
    instin = 16'h0531; branch_adder_in = 16'h1111; writedata = 16'hFFFF; regwrite_in = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    @(negedge clk);
    reset = 1'b1;

    // Directed steps from the decode table and write-port corners.
    step(16'h0000, 16'h0A16, 16'h0000, 1'b0, 1'b1);
    chk("ba_0a16", branch_adder_out, 16'h0A16);
    step(16'h0531, 16'h0002, 16'h0000, 1'b0, 1'b1);
    chk("rtype_rd1", rd_data1, 16'h0001);
    chk("rtype_rd2", rd_data2, 16'h0002);
    chk("rtype_ctrl", ctrl_obs(), 16'h0182);
    step(16'h0531, 16'h0004, 16'h1234, 1'b1, 1'b1);
    step(16'h0C00, 16'h0006, 16'h0000, 1'b0, 1'b1);
    chk("reg3_written", rd_data1, 16'h1234);
    step(16'h207F, 16'h0008, 16'h0000, 1'b0, 1'b1);
    chk("sext_ffff", sign_ext, 16'hFFFF);
    step(16'hC000, 16'h000A, 16'h0000, 1'b0, 1'b1);
    step(16'hE000, 16'h000C, 16'h0000, 1'b0, 1'b1);
    step(16'h8000, 16'h000E, 16'h0000, 1'b0, 1'b1);
    step(16'hA000, 16'h0010, 16'h0000, 1'b0, 1'b1);
    step(16'h0000, 16'h0012, 16'hBEEF, 1'b1, 1'b1);
    step(16'h0000, 16'h0014, 16'h0000, 1'b0, 1'b1);
    chk("reg0_zero", rd_data1, 16'h0000);
    // addi r3 <- r3: read and write of the same register in one edge
    step(16'h2D80, 16'h0016, 16'hCAFE, 1'b1, 1'b1);
    step(16'h0C00, 16'h0018, 16'h0000, 1'b0, 1'b1);
    chk("reg3_after_rw", rd_data1, 16'hCAFE);

    // Unknown instruction with write disabled must leave the file intact.
    instin = 16'hxxxx; regwrite_in = 1'b0;
    @(posedge clk);
    #1;
    for (int r = 0; r < 8; r++) step({3'd0, 3'(r), 3'(r), 7'd0}, 16'h0, 16'h0, 1'b0, 1'b0);

    // Random instructions and write-backs.
    for (int n = 0; n < 300; n++) begin
      step(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset in the middle of a pending write.
    step(16'h0C00, 16'h1357, 16'h0000, 1'b0, 1'b1);
    instin = 16'h0531; writedata = 16'h5555; regwrite_in = 1'b1; branch_adder_in = 16'h2468;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(16'h0C00, 16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("reg3_reset_val", rd_data1, 16'h0003);
    for (int r = 0; r < 8; r++) step({3'd0, 3'(r), 3'(7 - r), 7'd0}, 16'h0, 16'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
